seq_control_fsm: RTL and testbench

SEQ_CONTROL_FSM -- requirements
Module: seq_control_fsm

---
 rtl/seq_control_fsm.sv | 111 +++++++++++
 tb/tb_seq_control_fsm.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/seq_control_fsm.sv
// seq_control_fsm: multi-cycle instruction sequencer with registered Moore control strobes.
module seq_control_fsm (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       start,
  input  logic       step_mode,
  input  logic [3:0] opcode,
  input  logic [2:0] funct,
  input  logic       Zero,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       ALUSrc,
  output logic       ResultSrc,
  output logic [3:0] ALUControl,
  output logic [2:0] state,
  output logic       retire,
  output logic       halted,
  output logic       illegal,
  output logic [7:0] instr_count
);
  typedef enum logic [2:0] {IDLE = 3'd0, FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  localparam logic [3:0] OP_ALUR = 4'h0, OP_ALUI = 4'h1, OP_LOAD = 4'h2, OP_STORE = 4'h3;
  localparam logic [3:0] OP_BEQ = 4'h4, OP_JUMP = 4'h5, OP_HALT = 4'hf;
  state_t     state_q, state_d, ret_st;
  logic [3:0] op_q, op_d, ctl_q, ctl_d;
  logic [2:0] fn_q, fn_d;
  logic       ill_q, ill_d, legal;
  logic       ir_q, ret_q, reg_q, mem_q, src_q, res_q, hlt_q, beq_q, jmp_q;
  logic [7:0] cnt_q;
  assign legal  = opcode <= OP_JUMP;
  assign ret_st = step_mode ? IDLE : FETCH;
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    fn_d    = fn_q;
    ill_d   = ill_q;
    case (state_q)
      IDLE:   state_d = start ? FETCH : IDLE;
      FETCH:  state_d = DECODE;
      DECODE: begin
        op_d    = opcode;
        fn_d    = funct;
        state_d = legal ? EXEC : HALT;
        ill_d   = ill_q | (!legal && opcode != OP_HALT);
      end
      EXEC:   state_d = (op_q == OP_ALUR || op_q == OP_ALUI) ? WB :
                        (op_q == OP_LOAD || op_q == OP_STORE) ? MEM : ret_st;
      MEM:    state_d = op_q == OP_LOAD ? WB : ret_st;
      WB:     state_d = ret_st;
      HALT:   state_d = HALT;
      default: begin
        state_d = HALT;
        ill_d   = 1'b1;
      end
    endcase
  end
  assign ctl_d = op_d == OP_ALUR ? {1'b0, fn_d} : op_d == OP_BEQ ? 4'd1 : 4'd0;
  // Strobes are registered from the next state so they line up with state_q.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      op_q    <= '0;
      fn_q    <= '0;
      ill_q   <= 1'b0;
      ir_q    <= 1'b0;
      ret_q   <= 1'b0;
      reg_q   <= 1'b0;
      mem_q   <= 1'b0;
      src_q   <= 1'b0;
      res_q   <= 1'b0;
      hlt_q   <= 1'b0;
      beq_q   <= 1'b0;
      jmp_q   <= 1'b0;
      ctl_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      fn_q    <= fn_d;
      ill_q   <= ill_d;
      ir_q    <= state_d == FETCH;
      ret_q   <= state_d == WB || (state_d == MEM && op_d == OP_STORE) ||
                 (state_d == EXEC && (op_d == OP_BEQ || op_d == OP_JUMP));
      reg_q   <= state_d == WB;
      res_q   <= state_d == WB && op_d == OP_LOAD;
      mem_q   <= state_d == MEM && op_d == OP_STORE;
      src_q   <= state_d == EXEC && (op_d == OP_ALUI || op_d == OP_LOAD || op_d == OP_STORE);
      beq_q   <= state_d == EXEC && op_d == OP_BEQ;
      jmp_q   <= state_d == EXEC && op_d == OP_JUMP;
      hlt_q   <= state_d == HALT;
      ctl_q   <= ctl_d;
      cnt_q   <= cnt_q + {7'd0, ret_q};
    end
  end
  assign IRWrite     = ir_q;
  assign PCWrite     = ret_q;
  assign retire      = ret_q;
  assign PCSrc       = jmp_q | (beq_q & Zero);
  assign RegWrite    = reg_q;
  assign MemWrite    = mem_q;
  assign ALUSrc      = src_q;
  assign ResultSrc   = res_q;
  assign ALUControl  = ctl_q;
  assign state       = state_q;
  assign halted      = hlt_q;
  assign illegal     = ill_q;
  assign instr_count = cnt_q;
endmodule

// File: tb/tb_seq_control_fsm.sv
// tb_seq_control_fsm: random and directed stimulus checked against an instruction-plan reference model.
module tb_seq_control_fsm;
  logic       CLK = 1'b0, RST_N = 1'b1, start = 1'b0, step_mode = 1'b0, Zero = 1'b0;
  logic [3:0] opcode = '0;
  logic [2:0] funct = '0;
  logic       IRWrite, PCWrite, PCSrc, RegWrite, MemWrite, ALUSrc, ResultSrc, retire, halted, illegal;
  logic [3:0] ALUControl;
  logic [2:0] state;
  logic [7:0] instr_count;

  seq_control_fsm dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .step_mode(step_mode), .opcode(opcode),
    .funct(funct), .Zero(Zero), .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .ALUSrc(ALUSrc), .ResultSrc(ResultSrc),
    .ALUControl(ALUControl), .state(state), .retire(retire), .halted(halted),
    .illegal(illegal), .instr_count(instr_count)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0, n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the current state code plus the queue of states the
  // instruction still has to visit; the last one in the queue retires it.
  int         m_st, m_cnt;
  int         m_path[$];
  logic [3:0] m_op;
  logic [2:0] m_fn;
  logic       m_ill;

  task automatic m_reset();
    m_st = 0; m_cnt = 0; m_op = '0; m_fn = '0; m_ill = 1'b0;
    m_path.delete();
  endtask

  function automatic logic m_ret();
    return (m_st == 3 || m_st == 4 || m_st == 5) && m_path.size() == 0;
  endfunction

  function automatic logic [13:0] m_ctl(input logic z);
    logic       r;
    logic [3:0] ac;
    r  = m_ret();
    ac = m_op == 4'd0 ? {1'b0, m_fn} : m_op == 4'd4 ? 4'd1 : 4'd0;
    return {m_st == 1, r, r && (m_op == 4'd5 || (m_op == 4'd4 && z)), m_st == 5,
            m_st == 4 && m_op == 4'd3, m_st == 3 && m_op >= 4'd1 && m_op <= 4'd3,
            m_st == 5 && m_op == 4'd2, ac, r, m_st == 6, m_ill};
  endfunction

  task automatic m_step();
    case (m_st)
      0: if (start) m_st = 1;
      1: m_st = 2;
      2: begin
        m_op = opcode;
        m_fn = funct;
        if (opcode == 4'hf) m_st = 6;
        else if (opcode > 4'd5) begin m_st = 6; m_ill = 1'b1; end
        else begin
          case (opcode)
            4'd0, 4'd1: m_path = '{3, 5};
            4'd2:       m_path = '{3, 4, 5};
            4'd3:       m_path = '{3, 4};
            default:    m_path = '{3};
          endcase
          m_st = m_path.pop_front();
        end
      end
      3, 4, 5: begin
        if (m_path.size() == 0) begin
          m_cnt = (m_cnt + 1) % 256;
          m_st  = step_mode ? 0 : 1;
        end else m_st = m_path.pop_front();
      end
      default: ;
    endcase
  endtask

  task automatic check_all();
    check("state", 32'(state), 32'(m_st));
    check("ctl", 32'({IRWrite, PCWrite, PCSrc, RegWrite, MemWrite, ALUSrc, ResultSrc,
                      ALUControl, retire, halted, illegal}), 32'(m_ctl(Zero)));
    check("count", 32'(instr_count), 32'(m_cnt));
  endtask

  task automatic cyc(input logic s, input logic sm, input logic [3:0] op, input logic [2:0] fn,
                     input logic z);
    @(negedge CLK);
    start = s; step_mode = sm; opcode = op; funct = fn; Zero = z;
    #1;
    check_all();
    m_step();
  endtask

  task automatic rst_pulse();
    #1 RST_N = 1'b0;
    start = 1'b0;
    #1 m_reset();
    check_all();
    @(negedge CLK);
    #2 RST_N = 1'b1;
  endtask

  function automatic logic [3:0] pick_op();
    int r;
    r = $urandom_range(0, 99);
    if (r < 86) return 4'($urandom_range(0, 5));
    if (r < 93) return 4'hf;
    return 4'($urandom_range(6, 14));
  endfunction

  int alur_seq[4] = '{1, 2, 3, 5};
  int hc = 0;

  initial begin
    rst_pulse();
    cyc(1, 0, 4'd0, 3'b010, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 4'd0, 3'b010, 0);
      check("alur_seq", 32'(state), 32'(alur_seq[i]));
      if (i == 2) check("alur_ctl", 32'(ALUControl), 32'h2);
    end
    cyc(0, 0, 4'd2, 3'd0, 0);
    check("alur_cnt", 32'(instr_count), 32'd1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 4'd2, 3'd5, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 4'd3, 3'd1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 4'd4, 3'd0, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 4'd4, 3'd0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 4'd5, 3'd0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 4'd1, 3'd7, 1);
    for (int i = 0; i < 12; i++) cyc(1, 0, 4'hf, 3'd0, 0);
    check("halt_st", 32'(halted), 32'd1);
    rst_pulse();
    for (int i = 0; i < 6; i++) cyc(1, 0, 4'd6, 3'd0, 0);
    check("illegal", 32'(illegal), 32'd1);
    check("ill_cnt", 32'(instr_count), 32'd0);
    rst_pulse();
    cyc(1, 1, 4'd1, 3'd0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 4'd1, 3'd0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 4'd1, 3'd0, 0);
    check("step_idle", 32'(state), 32'd0);
    for (int i = 0; i < 5; i++) cyc(i == 0, 1, 4'd1, 3'd0, 0);
    rst_pulse();
    cyc(1, 0, 4'd5, 3'd0, 0);
    for (int i = 0; i < 768; i++) cyc(0, 0, 4'd5, 3'd0, 0);
    cyc(0, 0, 4'd3, 3'd0, 0);
    check("wrap", 32'(instr_count), 32'd0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 4'd3, 3'd0, 0);
    check("st_mem", 32'(MemWrite), 32'd1);
    rst_pulse();
    cyc(0, 0, 4'd3, 3'd0, 0);
    check("abort_st", 32'(state), 32'd0);
    check("abort_mw", 32'(MemWrite), 32'd0);
    for (int i = 0; i < 3000; i++) begin
      hc = m_st == 6 ? hc + 1 : 0;
      if (hc >= 4 || $urandom_range(0, 199) == 0) begin
        hc = 0;
        rst_pulse();
      end else
        cyc(1'($urandom_range(0, 1)), $urandom_range(0, 9) < 3, pick_op(),
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
